// File: rtl/mirror_block_fetch.sv
// Fetches one BLK x BLK pixel block at an offset position, padding outside the frame by
// mirroring or edge clamping, and packs LANES vertically adjacent pixels per output word.
module mirror_block_fetch #(
    parameter int IMG_W  = 1280,
    parameter int IMG_H  = 720,
    parameter int BLK    = 16,
    parameter int LANES  = 8,
    parameter int MAXOFF = 36,
    parameter int OFF_W  = 7,
    localparam int BX_W  = $clog2(IMG_W / BLK),
    localparam int BY_W  = $clog2(IMG_H / BLK),
    localparam int AW    = $clog2(IMG_W * IMG_H),
    localparam int LB    = $clog2(BLK),
    localparam int SEG_W = (BLK / LANES > 1) ? $clog2(BLK / LANES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BX_W-1:0]         blk_x,
    input  logic [BY_W-1:0]         blk_y,
    input  logic signed [OFF_W-1:0] off_x,
    input  logic signed [OFF_W-1:0] off_y,
    input  logic                    pad_mode,
    output logic                    busy,
    output logic                    mem_rd_en,
    output logic [AW-1:0]           mem_rd_addr,
    input  logic [7:0]              mem_rd_data,
    output logic                    out_we,
    output logic [LB-1:0]           out_col,
    output logic [SEG_W-1:0]        out_seg,
    output logic [8*LANES-1:0]      out_data,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              fsm_state
);

    // Handshake: start is sampled only while idle; mem_rd_data is consumed exactly one
    // cycle after each mem_rd_en, with no back-pressure; out_we is a one-cycle push.

    localparam int CW     = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 2;
    localparam int IW     = 2 * LB;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LL     = $clog2(LANES);

    localparam logic signed [CW-1:0]    W_S      = CW'(IMG_W);
    localparam logic signed [CW-1:0]    H_S      = CW'(IMG_H);
    localparam logic signed [CW-1:0]    ONE_S    = CW'(1);
    localparam logic [AW-1:0]           W_A      = AW'(IMG_W);
    localparam logic signed [OFF_W:0]   MAX_S    = (OFF_W + 1)'(MAXOFF);
    localparam logic [IW-1:0]           LAST_IDX = '1;
    localparam logic [LANE_W-1:0]       LAST_LN  = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [BX_W-1:0]         bx_q;
    logic [BY_W-1:0]         by_q;
    logic signed [OFF_W-1:0] ox_q;
    logic signed [OFF_W-1:0] oy_q;
    logic                    pad_q;

    logic [IW-1:0]       rd_idx;
    logic [IW-1:0]       ret_idx;
    logic [LANE_W-1:0]   lane_cnt;
    logic [8*LANES-1:0]  pack;
    logic [8*LANES-1:0]  pack_nx;
    logic                rd_valid;
    logic                out_last;
    logic                offs_ok;
    logic                accept;
    logic                reject;
    logic [AW-1:0]       addr_nx;

    function automatic logic off_ok(input logic signed [OFF_W-1:0] o);
        logic signed [OFF_W:0] w;
        w = (OFF_W + 1)'(o);
        return (w <= MAX_S) && (w >= -MAX_S);
    endfunction

    // Maps a raw signed coordinate into [0, n); ~p equals -1-p in two's complement.
    function automatic logic signed [CW-1:0] fold(input logic signed [CW-1:0] p,
                                                  input logic signed [CW-1:0] n,
                                                  input logic pad);
        logic signed [CW-1:0] r;
        r = p;
        if (p[CW-1]) begin
            r = pad ? '0 : ~p;
        end else if (p >= n) begin
            r = pad ? (n - ONE_S) : ((n <<< 1) - ONE_S - p);
        end
        return r;
    endfunction

    // idx is the column-major read index: upper half is the column, lower half the row.
    function automatic logic [AW-1:0] pix_addr(input logic [BX_W-1:0] bx,
                                               input logic [BY_W-1:0] by,
                                               input logic signed [OFF_W-1:0] ox,
                                               input logic signed [OFF_W-1:0] oy,
                                               input logic pad,
                                               input logic [IW-1:0] idx);
        logic signed [CW-1:0] px;
        logic signed [CW-1:0] py;
        px = signed'(CW'({bx, idx[IW-1:LB]})) + CW'(ox);
        py = signed'(CW'({by, idx[LB-1:0]})) + CW'(oy);
        px = fold(px, W_S, pad);
        py = fold(py, H_S, pad);
        return AW'(py) * W_A + AW'(px);
    endfunction

    assign offs_ok   = off_ok(off_x) && off_ok(off_y);
    assign accept    = (state == IDLE) && start && offs_ok;
    assign reject    = (state == IDLE) && start && !offs_ok;
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign pack_nx   = (pack << 8) | (8 * LANES)'(mem_rd_data);

    // The first address comes straight from the inputs so reading starts the next cycle.
    always_comb begin
        addr_nx = '0;
        if (state == IDLE) begin
            addr_nx = pix_addr(blk_x, blk_y, off_x, off_y, pad_mode, '0);
        end else begin
            addr_nx = pix_addr(bx_q, by_q, ox_q, oy_q, pad_q, rd_idx + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FETCH;
            FETCH:   if (rd_idx == LAST_IDX) state_nx = DRAIN;
            DRAIN:   if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bx_q        <= '0;
            by_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            pad_q       <= 1'b0;
            rd_idx      <= '0;
            ret_idx     <= '0;
            lane_cnt    <= '0;
            pack        <= '0;
            rd_valid    <= 1'b0;
            out_last    <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_we      <= 1'b0;
            out_col     <= '0;
            out_seg     <= '0;
            out_data    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            err      <= reject;
            out_we   <= 1'b0;
            done     <= out_we && out_last;
            rd_valid <= mem_rd_en;

            if (accept) begin
                bx_q        <= blk_x;
                by_q        <= blk_y;
                ox_q        <= off_x;
                oy_q        <= off_y;
                pad_q       <= pad_mode;
                rd_idx      <= '0;
                ret_idx     <= '0;
                lane_cnt    <= '0;
                pack        <= '0;
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= addr_nx;
            end else if (state == FETCH) begin
                if (rd_idx == LAST_IDX) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    rd_idx      <= rd_idx + 1'b1;
                    mem_rd_addr <= addr_nx;
                end
            end

            // Return side tracks its own index; column-major order keeps a word in one column.
            if (rd_valid) begin
                pack    <= pack_nx;
                ret_idx <= ret_idx + 1'b1;
                if (lane_cnt == LAST_LN) begin
                    lane_cnt <= '0;
                    out_we   <= 1'b1;
                    out_data <= pack_nx;
                    out_col  <= ret_idx[IW-1:LB];
                    out_seg  <= SEG_W'(ret_idx[LB-1:0] >> LL);
                    out_last <= (ret_idx == LAST_IDX);
                end else begin
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mirror_block_fetch.sv
// Directed and randomized block fetches checked cycle by cycle against a coordinate-level
// model of the padding rules and an addressable pixel memory.
module tb_mirror_block_fetch;

    localparam int IMG_W  = 1280;
    localparam int IMG_H  = 720;
    localparam int BLK    = 16;
    localparam int LANES  = 8;
    localparam int MAXOFF = 36;
    localparam int OFF_W  = 7;
    localparam int BX_W   = $clog2(IMG_W / BLK);
    localparam int BY_W   = $clog2(IMG_H / BLK);
    localparam int AW     = $clog2(IMG_W * IMG_H);
    localparam int LB     = $clog2(BLK);
    localparam int SEG_W  = 1;
    localparam int NRD    = BLK * BLK;
    localparam int NWD    = NRD / LANES;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [BX_W-1:0]         blk_x;
    logic [BY_W-1:0]         blk_y;
    logic signed [OFF_W-1:0] off_x;
    logic signed [OFF_W-1:0] off_y;
    logic                    pad_mode;
    logic                    busy;
    logic                    mem_rd_en;
    logic [AW-1:0]           mem_rd_addr;
    logic [7:0]              mem_rd_data = 8'h00;
    logic                    out_we;
    logic [LB-1:0]           out_col;
    logic [SEG_W-1:0]        out_seg;
    logic [8*LANES-1:0]      out_data;
    logic                    done;
    logic                    err;
    logic [1:0]              fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_count = 0;
    bit row_mode = 1'b0;

    mirror_block_fetch #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BLK(BLK), .LANES(LANES),
        .MAXOFF(MAXOFF), .OFF_W(OFF_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .blk_x(blk_x), .blk_y(blk_y),
        .off_x(off_x), .off_y(off_y), .pad_mode(pad_mode), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_we(out_we), .out_col(out_col), .out_seg(out_seg), .out_data(out_data),
        .done(done), .err(err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input int addr);
        return 8'((addr ^ (addr >> 8) ^ (addr >> 16)) & 255);
    endfunction

    // Frame memory: either a hash of the address, or the row inside the block being read.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= row_mode ? 8'(rd_count % BLK) : pix_of(int'(mem_rd_addr));
            rd_count    <= rd_count + 1;
        end else begin
            rd_count <= 0;
        end
    end

    function automatic int refl(input int p, input int n, input bit pad);
        if (p < 0) return pad ? 0 : -1 - p;
        if (p >= n) return pad ? n - 1 : 2 * n - 1 - p;
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " rd_en"}, 64'(mem_rd_en), 64'd0);
        check({tag, " rd_addr"}, 64'(mem_rd_addr), 64'd0);
        check({tag, " out_we"}, 64'(out_we), 64'd0);
        check({tag, " out_col"}, 64'(out_col), 64'd0);
        check({tag, " out_seg"}, 64'(out_seg), 64'd0);
        check({tag, " out_data"}, out_data, 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " err"}, 64'(err), 64'd0);
        check({tag, " state"}, 64'(fsm_state), 64'd0);
    endtask

    task automatic scramble_inputs();
        blk_x    = BX_W'($urandom_range(0, IMG_W / BLK - 1));
        blk_y    = BY_W'($urandom_range(0, IMG_H / BLK - 1));
        off_x    = OFF_W'($urandom_range(0, 2 * MAXOFF) - MAXOFF);
        off_y    = OFF_W'($urandom_range(0, 2 * MAXOFF) - MAXOFF);
        pad_mode = 1'($urandom_range(0, 1));
    endtask

    // Entered and left at #1 after a rising edge; the entry cycle is cycle 0.
    task automatic run_fetch(input int id, input int bx, input int by, input int ox,
                             input int oy, input bit pad, input int abort_at);
        int ea[NRD];
        logic [63:0] ew[NWD];
        int w;
        bit exp_rd;
        bit exp_we;
        string t;
        for (int a = 0; a < BLK; a++) begin
            for (int c = 0; c < BLK; c++) begin
                ea[a * BLK + c] = refl(by * BLK + c + oy, IMG_H, pad) * IMG_W
                                + refl(bx * BLK + a + ox, IMG_W, pad);
            end
        end
        for (int k = 0; k < NWD; k++) begin
            ew[k] = '0;
            for (int l = 0; l < LANES; l++) begin
                int i;
                i = (k / (BLK / LANES)) * BLK + (k % (BLK / LANES)) * LANES + l;
                ew[k] = (ew[k] << 8) | 64'(row_mode ? 8'(i % BLK) : pix_of(ea[i]));
            end
        end
        blk_x = BX_W'(bx); blk_y = BY_W'(by);
        off_x = OFF_W'(ox); off_y = OFF_W'(oy);
        pad_mode = pad; start = 1'b1;
        for (int n = 1; n <= 262; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                scramble_inputs();
            end
            if (n == 50) start = 1'b1;
            if (n == 51) start = 1'b0;
            t = $sformatf("run%0d c%0d", id, n);
            if (abort_at != 0 && n == abort_at + 1) begin
                check_zero({t, " abort"});
                reset = 1'b0;
                return;
            end
            exp_rd = (n <= NRD);
            check({t, " rd_en"}, 64'(mem_rd_en), 64'(exp_rd));
            if (exp_rd) check({t, " rd_addr"}, 64'(mem_rd_addr), 64'(ea[n - 1]));
            exp_we = (n >= LANES + 2) && (n <= NRD + 2) && ((n - LANES - 2) % LANES == 0);
            check({t, " out_we"}, 64'(out_we), 64'(exp_we));
            if (exp_we) begin
                w = (n - LANES - 2) / LANES;
                check({t, " out_col"}, 64'(out_col), 64'(w / (BLK / LANES)));
                check({t, " out_seg"}, 64'(out_seg), 64'(w % (BLK / LANES)));
                check({t, " out_data"}, out_data, ew[w]);
            end
            check({t, " done"}, 64'(done), 64'(n == NRD + 3));
            check({t, " busy"}, 64'(busy), 64'(n <= NRD + 3));
            check({t, " err"}, 64'(err), 64'd0);
            if (abort_at != 0 && n == abort_at) reset = 1'b1;
        end
    endtask

    task automatic run_bad(input int id, input int ox, input int oy);
        string t;
        scramble_inputs();
        off_x = OFF_W'(ox); off_y = OFF_W'(oy); start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            t = $sformatf("bad%0d c%0d", id, n);
            check({t, " err"}, 64'(err), 64'(n == 1));
            check({t, " rd_en"}, 64'(mem_rd_en), 64'd0);
            check({t, " busy"}, 64'(busy), 64'd0);
            check({t, " done"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        blk_x = '0; blk_y = '0; off_x = '0; off_y = '0; pad_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        run_fetch(1, 1, 1, 0, 0, 1'b0, 0);
        run_fetch(2, 0, 0, -3, -2, 1'b0, 0);
        run_fetch(3, 0, 0, -3, -2, 1'b1, 0);
        run_fetch(4, 79, 44, 5, 3, 1'b0, 0);
        run_fetch(5, 79, 44, 5, 3, 1'b1, 0);
        run_bad(1, 37, 0);
        run_bad(2, 0, -37);
        run_bad(3, -64, 20);

        row_mode = 1'b1;
        run_fetch(6, 3, 7, 10, -20, 1'b0, 0);
        row_mode = 1'b0;

        run_fetch(7, 40, 20, -36, 36, 1'b0, 100);
        run_fetch(8, 40, 20, 36, -36, 1'b1, 0);

        for (int r = 0; r < 4; r++) begin
            run_fetch(9 + r, int'($urandom_range(0, IMG_W / BLK - 1)),
                      int'($urandom_range(0, IMG_H / BLK - 1)),
                      int'($urandom_range(0, 2 * MAXOFF)) - MAXOFF,
                      int'($urandom_range(0, 2 * MAXOFF)) - MAXOFF,
                      1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
